// File: rtl/quadrilatero_csr_access_unit.sv
// Matrix-extension CSR access unit: read-modify-write of the matrix CSRs,
// field masking, illegal-access detection and busy stalling for config writes.
module quadrilatero_csr_access_unit #(
    parameter int          RLEN         = 4096,
    parameter int          ID_WIDTH     = 4,
    parameter logic [31:0] XMCSR_WMASK  = 32'h0000_0003,
    parameter logic [31:0] XMSIZE_WMASK = 32'h00FF_FFFF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [11:0]         req_addr_i,
    input  logic [1:0]          req_op_i,
    input  logic                req_wr_en_i,
    input  logic [31:0]         req_wdata_i,
    input  logic [ID_WIDTH-1:0] req_id_i,
    input  logic                matrix_busy_i,
    input  logic [31:0]         xmrstart_i,
    input  logic [31:0]         xmcsr_i,
    input  logic [31:0]         xmsize_i,
    output logic                csr_we_o,
    output logic [11:0]         csr_waddr_o,
    output logic [31:0]         csr_wdata_o,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_rdata_o,
    output logic [ID_WIDTH-1:0] resp_id_o,
    output logic                resp_exc_o
);

    localparam int N_ROWS = RLEN / 32;

    localparam logic [31:0] XMRSTART_WMASK = 32'(N_ROWS - 1);
    localparam logic [31:0] XMLENB_VAL     = 32'(N_ROWS * RLEN / 8);
    localparam logic [31:0] XRLENB_VAL     = 32'(RLEN / 8);
    localparam logic [31:0] XMISA_VAL      = 32'h0000_0010;

    localparam logic [11:0] A_XMRSTART = 12'h802;
    localparam logic [11:0] A_XMCSR    = 12'h803;
    localparam logic [11:0] A_XMSIZE   = 12'h804;
    localparam logic [11:0] A_XMLENB   = 12'hCC0;
    localparam logic [11:0] A_XRLENB   = 12'hCC1;
    localparam logic [11:0] A_XMISA    = 12'hCC2;

    localparam logic [1:0] OP_RW  = 2'b00;
    localparam logic [1:0] OP_RS  = 2'b01;
    localparam logic [1:0] OP_RC  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t state_q;

    logic [11:0]         addr_q;
    logic [1:0]          op_q;
    logic                wr_en_q;
    logic [31:0]         wdata_q;
    logic [ID_WIDTH-1:0] id_q;

    function automatic logic is_rw_csr(input logic [11:0] a);
        return (a == A_XMRSTART) || (a == A_XMCSR) || (a == A_XMSIZE);
    endfunction

    function automatic logic is_ro_csr(input logic [11:0] a);
        return (a == A_XMLENB) || (a == A_XRLENB) || (a == A_XMISA);
    endfunction

    // A legal write to a config CSR must not race in-flight matrix work.
    logic in_wr_intent;
    logic in_needs_wait;

    always_comb begin
        in_wr_intent  = (req_op_i == OP_RW) || req_wr_en_i;
        in_needs_wait = matrix_busy_i
                      && (req_op_i != 2'b11)
                      && in_wr_intent
                      && is_rw_csr(req_addr_i);
    end

    logic accept;
    assign req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    logic        q_wr_intent;
    logic        q_rw;
    logic        q_ro;
    logic        q_exc;
    logic        q_write;
    logic [31:0] old_val;
    logic [31:0] wmask;
    logic [31:0] new_val;
    logic [31:0] merged;

    always_comb begin
        q_wr_intent = (op_q == OP_RW) || wr_en_q;
        q_rw        = is_rw_csr(addr_q);
        q_ro        = is_ro_csr(addr_q);
        q_exc       = (op_q == 2'b11) || !(q_rw || q_ro) || (q_ro && q_wr_intent);
        q_write     = !q_exc && q_wr_intent && q_rw;

        old_val = 32'h0;
        wmask   = 32'h0;
        case (addr_q)
            A_XMRSTART: begin old_val = xmrstart_i; wmask = XMRSTART_WMASK; end
            A_XMCSR:    begin old_val = xmcsr_i;    wmask = XMCSR_WMASK;    end
            A_XMSIZE:   begin old_val = xmsize_i;   wmask = XMSIZE_WMASK;   end
            A_XMLENB:   old_val = XMLENB_VAL;
            A_XRLENB:   old_val = XRLENB_VAL;
            A_XMISA:    old_val = XMISA_VAL;
            default:    old_val = 32'h0;
        endcase

        case (op_q)
            OP_RW:   new_val = wdata_q;
            OP_RS:   new_val = old_val | wdata_q;
            OP_RC:   new_val = old_val & ~wdata_q;
            default: new_val = old_val;
        endcase

        merged = (new_val & wmask) | (old_val & ~wmask);
    end

    // Strobe is qualified by reset so a pending request is never written.
    logic do_we;
    assign do_we       = (state_q == S_EXEC) && q_write && !rst_i;
    assign csr_we_o    = do_we;
    assign csr_waddr_o = do_we ? addr_q : 12'h0;
    assign csr_wdata_o = do_we ? merged : 32'h0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            addr_q       <= 12'h0;
            op_q         <= 2'b00;
            wr_en_q      <= 1'b0;
            wdata_q      <= 32'h0;
            id_q         <= '0;
            resp_valid_o <= 1'b0;
            resp_rdata_o <= 32'h0;
            resp_id_o    <= '0;
            resp_exc_o   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr_i;
                        op_q    <= req_op_i;
                        wr_en_q <= req_wr_en_i;
                        wdata_q <= req_wdata_i;
                        id_q    <= req_id_i;
                        state_q <= in_needs_wait ? S_WAIT : S_EXEC;
                    end
                end
                S_WAIT: begin
                    if (!matrix_busy_i) begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    resp_valid_o <= 1'b1;
                    resp_rdata_o <= q_exc ? 32'h0 : old_val;
                    resp_id_o    <= id_q;
                    resp_exc_o   <= q_exc;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quadrilatero_csr_access_unit.sv
// Directed bench for quadrilatero_csr_access_unit with hand-computed
// expectations for latency, masking, stalls and illegal accesses.
module tb_quadrilatero_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic [1:0]  req_op;
    logic        req_wr_en;
    logic [31:0] req_wdata;
    logic [3:0]  req_id;
    logic        busy;
    logic [31:0] xmrstart;
    logic [31:0] xmcsr;
    logic [31:0] xmsize;
    logic        csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [3:0]  resp_id;
    logic        resp_exc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quadrilatero_csr_access_unit dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_op_i     (req_op),
        .req_wr_en_i  (req_wr_en),
        .req_wdata_i  (req_wdata),
        .req_id_i     (req_id),
        .matrix_busy_i(busy),
        .xmrstart_i   (xmrstart),
        .xmcsr_i      (xmcsr),
        .xmsize_i     (xmsize),
        .csr_we_o     (csr_we),
        .csr_waddr_o  (csr_waddr),
        .csr_wdata_o  (csr_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_id_o    (resp_id),
        .resp_exc_o   (resp_exc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request for exactly one cycle; returns in the cycle after accept.
    task automatic issue(input logic [1:0] op, input logic [11:0] a,
                         input logic we, input logic [31:0] d, input logic [3:0] id);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_wr_en = we;
        req_wdata = d;
        req_id    = id;
        tick();
        req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL rst_we got %0h want 0", csr_we); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %0h want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0 || resp_id !== 4'h0 || resp_exc !== 1'b0)
            begin errors++; $display("FAIL rst_resp got %h/%h/%h want 0/0/0", resp_rdata, resp_id, resp_exc); end
        checks++; if (csr_waddr !== 12'h0 || csr_wdata !== 32'h0)
            begin errors++; $display("FAIL rst_wbus got %h/%h want 0/0", csr_waddr, csr_wdata); end
        rst = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h want 1", req_ready); end
        tick();
    endtask

    task automatic test_rw_xmrstart();
        xmrstart = 32'h0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL t1_ready got %0h want 1", req_ready); end
        issue(2'b00, 12'h802, 1'b0, 32'h5, 4'h3);
        checks++; if (csr_we !== 1'b1) begin errors++; $display("FAIL t1_we got %0h want 1", csr_we); end
        checks++; if (csr_waddr !== 12'h802) begin errors++; $display("FAIL t1_waddr got %h want 802", csr_waddr); end
        checks++; if (csr_wdata !== 32'h5) begin errors++; $display("FAIL t1_wdata got %h want 5", csr_wdata); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL t1_early_rvalid got %0h want 0", resp_valid); end
        tick();
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL t1_we_off got %0h want 0", csr_we); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL t1_rvalid got %0h want 1", resp_valid); end
        checks++; if (resp_rdata !== 32'h0 || resp_exc !== 1'b0 || resp_id !== 4'h3)
            begin errors++; $display("FAIL t1_resp got %h/%h/%h want 0/0/3", resp_rdata, resp_exc, resp_id); end
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL t1_idle got %0h/%0h want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_busy_stall();
        xmsize = 32'hAB00_0001;
        busy   = 1'b1;
        issue(2'b01, 12'h804, 1'b1, 32'h100, 4'h7);
        for (int i = 0; i < 3; i++) begin
            checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL t2_we_busy%0d got %0h want 0", i, csr_we); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_busy%0d got %0h want 0", i, req_ready); end
            if (i == 2) busy = 1'b0;
            tick();
        end
        checks++; if (csr_we !== 1'b1 || csr_waddr !== 12'h804)
            begin errors++; $display("FAIL t2_we got %0h/%h want 1/804", csr_we, csr_waddr); end
        checks++; if (csr_wdata !== 32'hAB00_0101) begin errors++; $display("FAIL t2_wdata got %h want ab000101", csr_wdata); end
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hAB00_0001 || resp_id !== 4'h7)
            begin errors++; $display("FAIL t2_resp got %0h/%h/%h want 1/ab000001/7", resp_valid, resp_rdata, resp_id); end
        tick();
    endtask

    task automatic test_read_only();
        issue(2'b00, 12'hCC2, 1'b0, 32'h1234, 4'h1);
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL t3_ro_we got %0h want 0", csr_we); end
        tick();
        checks++; if (resp_exc !== 1'b1 || resp_rdata !== 32'h0)
            begin errors++; $display("FAIL t3_ro_exc got %0h/%h want 1/0", resp_exc, resp_rdata); end
        tick();
        issue(2'b01, 12'hCC1, 1'b0, 32'h0, 4'h2);
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL t3_rd_we got %0h want 0", csr_we); end
        tick();
        checks++; if (resp_exc !== 1'b0 || resp_rdata !== 32'd512)
            begin errors++; $display("FAIL t3_xrlenb got %0h/%0d want 0/512", resp_exc, resp_rdata); end
        tick();
        issue(2'b01, 12'hCC2, 1'b0, 32'h0, 4'h4);
        tick();
        checks++; if (resp_exc !== 1'b0 || resp_rdata !== 32'h10)
            begin errors++; $display("FAIL t3_xmisa got %0h/%h want 0/10", resp_exc, resp_rdata); end
        tick();
    endtask

    task automatic test_xmcsr_mask();
        xmcsr = 32'h3;
        issue(2'b10, 12'h803, 1'b1, 32'h1, 4'h5);
        checks++; if (csr_we !== 1'b1 || csr_wdata !== 32'h2)
            begin errors++; $display("FAIL t4_rc got %0h/%h want 1/2", csr_we, csr_wdata); end
        tick();
        checks++; if (resp_rdata !== 32'h3) begin errors++; $display("FAIL t4_rc_old got %h want 3", resp_rdata); end
        tick();
        xmcsr = 32'h0;
        issue(2'b00, 12'h803, 1'b0, 32'hFF, 4'h6);
        checks++; if (csr_we !== 1'b1 || csr_wdata !== 32'h3)
            begin errors++; $display("FAIL t4_rw got %0h/%h want 1/3", csr_we, csr_wdata); end
        tick();
        tick();
        issue(2'b01, 12'h7C0, 1'b0, 32'h0, 4'h8);
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL t4_bad_we got %0h want 0", csr_we); end
        tick();
        checks++; if (resp_exc !== 1'b1 || resp_rdata !== 32'h0)
            begin errors++; $display("FAIL t4_bad_exc got %0h/%h want 1/0", resp_exc, resp_rdata); end
        tick();
        issue(2'b11, 12'h803, 1'b0, 32'h1, 4'h9);
        checks++; if (csr_we !== 1'b0) begin errors++; $display("FAIL t4_op3_we got %0h want 0", csr_we); end
        tick();
        checks++; if (resp_exc !== 1'b1) begin errors++; $display("FAIL t4_op3_exc got %0h want 1", resp_exc); end
        tick();
    endtask

    task automatic test_resp_backpressure();
        resp_ready = 1'b0;
        issue(2'b01, 12'hCC0, 1'b0, 32'h0, 4'hA);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'd65536 || resp_id !== 4'hA || resp_exc !== 1'b0)
                begin errors++; $display("FAIL t5_hold%0d got %0h/%0d/%h/%0h want 1/65536/a/0", i, resp_valid, resp_rdata, resp_id, resp_exc); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL t5_ready%0d got %0h want 0", i, req_ready); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL t5_release got %0h/%0h want 0/1", resp_valid, req_ready); end
    endtask

    task automatic test_back_to_back();
        xmrstart = 32'h0;
        issue(2'b00, 12'h802, 1'b0, 32'hFFFF_FFFF, 4'hB);
        checks++; if (csr_wdata !== 32'h7F) begin errors++; $display("FAIL t7_mask got %h want 7f", csr_wdata); end
        tick();
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL t7_ready got %0h want 1", req_ready); end
        xmsize = 32'h1200_0000;
        issue(2'b00, 12'h804, 1'b0, 32'hFFFF_FFFF, 4'hC);
        checks++; if (csr_wdata !== 32'h12FF_FFFF) begin errors++; $display("FAIL t7_xmsize got %h want 12ffffff", csr_wdata); end
        tick();
        tick();
    endtask

    task automatic test_reset_in_wait();
        busy = 1'b1;
        issue(2'b00, 12'h803, 1'b0, 32'h3, 4'hD);
        checks++; if (req_ready !== 1'b0 || csr_we !== 1'b0)
            begin errors++; $display("FAIL t6_wait got %0h/%0h want 0/0", req_ready, csr_we); end
        tick();
        rst = 1'b1;
        tick();
        checks++; if (csr_we !== 1'b0 || resp_valid !== 1'b0)
            begin errors++; $display("FAIL t6_inrst got %0h/%0h want 0/0", csr_we, resp_valid); end
        rst  = 1'b0;
        busy = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL t6_ready got %0h want 1", req_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (csr_we !== 1'b0 || resp_valid !== 1'b0)
                begin errors++; $display("FAIL t6_after%0d got %0h/%0h want 0/0", i, csr_we, resp_valid); end
        end
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 12'h0;
        req_op     = 2'b00;
        req_wr_en  = 1'b0;
        req_wdata  = 32'h0;
        req_id     = 4'h0;
        busy       = 1'b0;
        xmrstart   = 32'h0;
        xmcsr      = 32'h0;
        xmsize     = 32'h0;
        resp_ready = 1'b1;
        #1;
        test_reset();
        test_rw_xmrstart();
        test_busy_stall();
        test_read_only();
        test_xmcsr_mask();
        test_resp_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
